// File: rtl/sm4_word_adapter.sv
// sm4_word_adapter
// Bridges a 32-bit valid/ready plaintext stream to a 128-bit SM4 block core
// and streams the 128-bit result back out as four 32-bit ciphertext words.
// Word order on both streams: first word <-> bits [127:96].
// Optional RUN watchdog: define SM4_ADAPTER_TIMEOUT_EN to build the 6-bit
// timeout counter and the sticky ERR flag; otherwise ERR is tied low.
module sm4_word_adapter (
  input  logic         CLK,
  input  logic         RST,
  input  logic         KEY_LOAD,
  input  logic [127:0] KEY_IN,
  input  logic         S_VALID,
  output logic         S_READY,
  input  logic [31:0]  S_DATA,
  output logic         M_VALID,
  input  logic         M_READY,
  output logic [31:0]  M_DATA,
  output logic         CORE_RST_N,
  output logic         CORE_EN,
  output logic [127:0] CORE_DATA,
  output logic [127:0] CORE_KEY,
  input  logic [127:0] CORE_RESULT,
  input  logic         CORE_READY,
  output logic         BUSY,
  output logic         ERR
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CLR     = 3'd2,
    RUN     = 3'd3,
    EMIT    = 3'd4
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [1:0]     word_cnt;
  logic [1:0]     out_idx;
  logic [127:0]   data_reg;
  logic [127:0]   key_reg;
  logic [127:0]   result_reg;
  logic           core_clr;
  logic           s_beat;
  logic           m_beat;
  logic           core_done;
  logic           key_open;

  // A beat is accepted only in COLLECT because S_READY is a pure COLLECT decode.
  assign s_beat    = (state == COLLECT) && S_VALID;
  assign m_beat    = (state == EMIT) && M_READY;
  assign core_done = (state == RUN) && CORE_READY;
  assign key_open  = (state == IDLE) || (state == COLLECT);

`ifdef SM4_ADAPTER_TIMEOUT_EN
  logic [5:0] tmo_cnt;
  logic       tmo_hit;
  logic       err_reg;

  // The counter reaches 63 on the edge that closes the 63rd RUN cycle.
  assign tmo_hit = (state == RUN) && !CORE_READY && (tmo_cnt == 6'd62);
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments with the async reset
  // in the sensitivity list, so every flop samples pre-edge values and the
  // reset takes effect without waiting for a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and per-state control outputs.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    S_READY    = 1'b0;
    M_VALID    = 1'b0;
    CORE_EN    = 1'b0;
    BUSY       = 1'b0;
    core_clr   = 1'b0;
    case (state)
      IDLE: begin
        next_state = COLLECT;
      end
      COLLECT: begin
        S_READY = 1'b1;
        if (S_VALID && (word_cnt == 2'd3)) next_state = CLR;
      end
      CLR: begin
        BUSY       = 1'b1;
        core_clr   = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        BUSY    = 1'b1;
        CORE_EN = 1'b1;
        if (CORE_READY) next_state = EMIT;
`ifdef SM4_ADAPTER_TIMEOUT_EN
        else if (tmo_hit) next_state = COLLECT;
`endif
      end
      EMIT: begin
        BUSY    = 1'b1;
        M_VALID = 1'b1;
        if (M_READY && (out_idx == 2'd3)) next_state = COLLECT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // The core is held in reset while the adapter is reset and for the single
    // CLR cycle that separates consecutive blocks.
    CORE_RST_N = !RST && !core_clr;
  end

  // Plaintext word capture: word n lands in bits [127-32n -: 32].
  // NOTE: the wide data, key and result registers are reset too, so a reset
  // mid-block cannot leak a stale plaintext, key or ciphertext to either side.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_cnt <= 2'd0;
      data_reg <= '0;
    end else if (s_beat) begin
      // {~word_cnt, 5'd0} is (3 - word_cnt) * 32, the low bit of the slot.
      data_reg[{~word_cnt, 5'd0} +: 32] <= S_DATA;
      word_cnt <= word_cnt + 2'd1;
    end
  end

  // Key capture, open only while no block is in flight; a load on the fourth
  // input beat therefore still applies to that block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_reg <= '0;
    end else if (KEY_LOAD && key_open) begin
      key_reg <= KEY_IN;
    end
  end

  // Result capture on the single RUN cycle in which the core reports done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_reg <= '0;
    end else if (core_done) begin
      result_reg <= CORE_RESULT;
    end
  end

  // Output word index, advanced only by an accepted output beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_idx <= 2'd0;
    end else if (m_beat) begin
      out_idx <= out_idx + 2'd1;
    end
  end

`ifdef SM4_ADAPTER_TIMEOUT_EN
  // RUN watchdog: cleared in CLR (the only way into RUN), counts RUN cycles,
  // and latches ERR until the next adapter reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt <= 6'd0;
      err_reg <= 1'b0;
    end else begin
      if (state == CLR) begin
        tmo_cnt <= 6'd0;
      end else if ((state == RUN) && !CORE_READY) begin
        tmo_cnt <= tmo_cnt + 6'd1;
      end
      if (tmo_hit) err_reg <= 1'b1;
    end
  end

  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

  assign CORE_DATA = data_reg;
  assign CORE_KEY  = key_reg;
  // M_DATA depends only on registers, so it cannot move while a beat stalls.
  assign M_DATA    = result_reg[{~out_idx, 5'd0} +: 32];

endmodule

// File: tb/tb_sm4_word_adapter.sv
// tb_sm4_word_adapter
// Directed bench for sm4_word_adapter with a behavioural SM4 core model and a
// scoreboard queue of expected ciphertext words. Honours SM4_ADAPTER_TIMEOUT_EN.
module tb_sm4_word_adapter;

  localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KAT_PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [7:0] SBOX [0:255] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  logic         CLK = 1'b0;
  logic         RST;
  logic         KEY_LOAD;
  logic [127:0] KEY_IN;
  logic         S_VALID;
  logic         S_READY;
  logic [31:0]  S_DATA;
  logic         M_VALID;
  logic         M_READY;
  logic [31:0]  M_DATA;
  logic         CORE_RST_N;
  logic         CORE_EN;
  logic [127:0] CORE_DATA;
  logic [127:0] CORE_KEY;
  logic [127:0] CORE_RESULT = '0;
  logic         CORE_READY = 1'b0;
  logic         BUSY;
  logic         ERR;

  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_beats = 0;
  int           core_cnt = 0;
  bit           never_ready = 1'b0;
  bit           stalled = 1'b0;
  logic [31:0]  held = '0;
  logic [31:0]  exp_q [$];
  logic [127:0] tb_key = '0;

  sm4_word_adapter dut (
    .CLK(CLK), .RST(RST), .KEY_LOAD(KEY_LOAD), .KEY_IN(KEY_IN),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .CORE_RST_N(CORE_RST_N), .CORE_EN(CORE_EN), .CORE_DATA(CORE_DATA),
    .CORE_KEY(CORE_KEY), .CORE_RESULT(CORE_RESULT), .CORE_READY(CORE_READY),
    .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // ---------------- SM4 reference ----------------
  function automatic logic [31:0] rol(input logic [31:0] b, input int n);
    return (b << n) | (b >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] ck(input int i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w = {w[23:0], 8'((4 * i + j) * 7)};
    return w;
  endfunction

  function automatic logic [127:0] sm4_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] b;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    x[0] = pt[127:96]; x[1] = pt[95:64]; x[2] = pt[63:32]; x[3] = pt[31:0];
    for (int i = 0; i < 32; i++) begin
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Behavioural core: READY 32 cycles after EN rises, cleared by CORE_RST_N.
  always @(negedge CLK) begin
    if (!CORE_RST_N) begin
      core_cnt   = 0;
      CORE_READY = 1'b0;
    end else if (CORE_EN) begin
      if (core_cnt < 32) core_cnt++;
      if (core_cnt == 32 && !never_ready) begin
        CORE_READY  = 1'b1;
        CORE_RESULT = sm4_enc(CORE_DATA, CORE_KEY);
      end
    end else begin
      CORE_READY = 1'b0;
    end
  end

  // Output monitor: pops the scoreboard on each accepted beat, checks hold.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (M_VALID) begin
      checkb("s_ready_in_emit", S_READY, 1'b0);
      checkb("core_en_in_emit", CORE_EN, 1'b0);
      if (stalled) check("m_data_stall", 128'(M_DATA), 128'(held));
      if (M_READY) begin
        n_beats++;
        checkb("m_beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", 128'(M_DATA), 128'(e));
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = M_DATA;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic ld, input logic [127:0] k);
    int n;
    n = 0;
    while (!S_READY && n < 50) begin step(); n++; end
    checkb("s_ready_wait", S_READY, 1'b1);
    checkb("core_en_collect", CORE_EN, 1'b0);
    S_VALID  = 1'b1;
    S_DATA   = w;
    KEY_LOAD = ld;
    KEY_IN   = k;
    step();
    S_VALID  = 1'b0;
    KEY_LOAD = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic ld, input logic [127:0] k,
                            input logic [127:0] exp, input bit push);
    for (int i = 0; i < 4; i++) send_word(blk[127 - 32 * i -: 32], ld && (i == 3), k);
    if (ld) tb_key = k;
    if (push) for (int i = 0; i < 4; i++) exp_q.push_back(exp[127 - 32 * i -: 32]);
  endtask

  task automatic run_phase(input bit poke, output int n);
    logic [127:0] d0;
    logic [127:0] k0;
    checkb("core_rst_n_clr", CORE_RST_N, 1'b0);
    checkb("core_en_clr", CORE_EN, 1'b0);
    checkb("busy_clr", BUSY, 1'b1);
    step();
    checkb("core_rst_n_run", CORE_RST_N, 1'b1);
    d0 = CORE_DATA;
    k0 = CORE_KEY;
    n  = 0;
    while (CORE_EN && n < 100) begin
      if (poke && n == 5) begin KEY_LOAD = 1'b1; KEY_IN = '0; end
      else KEY_LOAD = 1'b0;
      n++;
      step();
    end
    KEY_LOAD = 1'b0;
    check("core_data_stable", CORE_DATA, d0);
    check("core_key_stable", CORE_KEY, k0);
  endtask

  task automatic emit_phase(input bit bp);
    logic [3:0] pat;
    int c;
    int b0;
    pat = 4'b1001;
    b0  = n_beats;
    c   = 0;
    while (M_VALID && c < 40) begin
      M_READY = bp ? pat[c % 4] : 1'b1;
      c++;
      step();
    end
    M_READY = 1'b1;
    check("emit_beats", 128'(n_beats - b0), 128'd4);
    checkb("m_valid_after_emit", M_VALID, 1'b0);
    checkb("s_ready_after_emit", S_READY, 1'b1);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkb({tag, "_s_ready"}, S_READY, 1'b0);
    checkb({tag, "_m_valid"}, M_VALID, 1'b0);
    check({tag, "_m_data"}, 128'(M_DATA), 128'd0);
    checkb({tag, "_core_en"}, CORE_EN, 1'b0);
    checkb({tag, "_core_rst_n"}, CORE_RST_N, 1'b0);
    checkb({tag, "_busy"}, BUSY, 1'b0);
    checkb({tag, "_err"}, ERR, 1'b0);
    check({tag, "_core_key"}, CORE_KEY, 128'd0);
    check({tag, "_core_data"}, CORE_DATA, 128'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [127:0] rblk;
    logic [127:0] rkey;
    RST = 1'b1; KEY_LOAD = 1'b0; KEY_IN = '0;
    S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst");

    // Release: one IDLE cycle, then COLLECT.
    RST = 1'b0;
    #1;
    checkb("idle_s_ready", S_READY, 1'b0);
    checkb("idle_core_rst_n", CORE_RST_N, 1'b1);
    step();
    checkb("collect_s_ready", S_READY, 1'b1);

    // Known answer, key loaded together with the fourth beat.
    send_block(KAT_PT, 1'b1, KAT_KEY, KAT_CT, 1'b1);
    run_phase(1'b0, n);
    check("run_len_kat", 128'(n), 128'd32);
    emit_phase(1'b0);
    checkb("err_after_kat", ERR, 1'b0);
    check("core_key_kat", CORE_KEY, KAT_KEY);

    // Key load attempted during RUN must be ignored.
    send_block(KAT_PT, 1'b0, '0, KAT_CT, 1'b1);
    run_phase(1'b1, n);
    check("core_key_after_poke", CORE_KEY, KAT_KEY);
    emit_phase(1'b0);

    // Output backpressure 1-0-0-1.
    send_block(KAT_PT, 1'b0, '0, KAT_CT, 1'b1);
    run_phase(1'b0, n);
    emit_phase(1'b1);

    // Fresh key loaded alone in COLLECT, random plaintext.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    rblk = {$urandom, $urandom, $urandom, $urandom};
    KEY_LOAD = 1'b1; KEY_IN = rkey;
    step();
    KEY_LOAD = 1'b0;
    tb_key = rkey;
    check("core_key_loaded", CORE_KEY, rkey);
    send_block(rblk, 1'b0, '0, sm4_enc(rblk, tb_key), 1'b1);
    run_phase(1'b0, n);
    emit_phase(1'b1);

    // Reset after two beats: partial block and key are discarded.
    send_word(32'hdeadbeef, 1'b0, '0);
    send_word(32'hcafef00d, 1'b0, '0);
    RST = 1'b1;
    step();
    check_reset_outputs("mid_rst");
    RST = 1'b0;
    tb_key = '0;
    step();
    repeat (3) step();
    checkb("no_beat_after_abort", M_VALID, 1'b0);
    send_block(KAT_PT, 1'b1, KAT_KEY, KAT_CT, 1'b1);
    run_phase(1'b0, n);
    emit_phase(1'b0);

    // Core that never finishes.
    never_ready = 1'b1;
    send_block(KAT_PT, 1'b0, '0, '0, 1'b0);
    run_phase(1'b0, n);
`ifdef SM4_ADAPTER_TIMEOUT_EN
    check("run_len_timeout", 128'(n), 128'd63);
    checkb("err_timeout", ERR, 1'b1);
    checkb("s_ready_timeout", S_READY, 1'b1);
    checkb("busy_timeout", BUSY, 1'b0);
    checkb("m_valid_timeout", M_VALID, 1'b0);
    never_ready = 1'b0;
    send_block(KAT_PT, 1'b0, '0, KAT_CT, 1'b1);
    run_phase(1'b0, n);
    emit_phase(1'b0);
    checkb("err_sticky", ERR, 1'b1);
    RST = 1'b1;
    step();
    checkb("err_cleared", ERR, 1'b0);
    RST = 1'b0;
    step();
`else
    check("run_len_no_timeout", 128'(n), 128'd100);
    checkb("err_tied_low", ERR, 1'b0);
    checkb("busy_waiting", BUSY, 1'b1);
    checkb("core_en_waiting", CORE_EN, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    never_ready = 1'b0;
    step();
`endif
    checkb("final_collect", S_READY, 1'b1);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sm4_word_adapter.md
SM4_WORD_ADAPTER -- requirements
Module: sm4_word_adapter

Interface
REQ-001 SHALL have ports: CLK in 1 (sole clock, rising edge); RST in 1 (asynchronous, active-high reset).
REQ-002 SHALL have KEY_LOAD in 1 (key capture strobe) and KEY_IN in 128 (user key).
REQ-003 SHALL have input stream ports: S_VALID in 1, S_READY out 1, S_DATA in 32 (plaintext words).
REQ-004 SHALL have output stream ports: M_VALID out 1, M_READY in 1, M_DATA out 32 (ciphertext words).
REQ-005 SHALL have core-facing ports: CORE_RST_N out 1, CORE_EN out 1, CORE_DATA out 128, CORE_KEY out 128, CORE_RESULT in 128, CORE_READY in 1.
REQ-006 SHALL have status ports: BUSY out 1 (state is CLR, RUN or EMIT) and ERR out 1 (sticky timeout flag).

Function
REQ-007 SHALL implement FSM states IDLE, COLLECT, CLR, RUN, EMIT.
REQ-008 IDLE SHALL be held during reset and SHALL go to COLLECT on the first clock after reset release.
REQ-009 COLLECT: S_READY=1; each S_VALID&S_READY beat SHALL store S_DATA into the data register, first word into [127:96] and fourth word into [31:0]; a 2-bit word counter SHALL track beats.
REQ-010 On the fourth accepted beat the counter SHALL wrap to 0 and the FSM SHALL enter CLR on the next cycle; S_READY SHALL be 0 in every state except COLLECT.
REQ-011 CLR SHALL last exactly one cycle with CORE_RST_N=0 and CORE_EN=0; CORE_RST_N SHALL be 1 in every other state.
REQ-012 RUN: CORE_EN=1, with CORE_DATA and CORE_KEY held stable; CORE_READY SHALL be sampled only in RUN.
REQ-013 When CORE_READY=1 in RUN, CORE_RESULT SHALL be captured into the result register and the FSM SHALL enter EMIT; CORE_EN SHALL be 0 from that next cycle.
REQ-014 EMIT: M_VALID=1; M_DATA SHALL be result word idx, with idx 0 being [127:96]; idx SHALL advance only on M_VALID&M_READY.
REQ-015 M_DATA SHALL stay stable while M_VALID=1 and M_READY=0.
REQ-016 After the fourth output beat, idx SHALL wrap to 0 and the FSM SHALL return to COLLECT; M_VALID SHALL drop in the following cycle.
REQ-017 KEY_LOAD=1 SHALL load KEY_IN into the key register (drives CORE_KEY) only in IDLE or COLLECT; in CLR, RUN or EMIT it SHALL be ignored.
REQ-018 If KEY_LOAD and the fourth S beat coincide, the new key SHALL be used for that block.
REQ-019 Blocks SHALL NOT overlap: minimum latency is 4 input beats + 1 (CLR) + core latency + 1 cycle to the first M_VALID.

Reset
REQ-020 RST=1 SHALL asynchronously force: state IDLE, counters 0, data/key/result registers 0, S_READY 0, M_VALID 0, M_DATA 0, CORE_EN 0, CORE_RST_N 0, BUSY 0, ERR 0.
REQ-021 RST asserted mid-block (any state) SHALL discard partial words and any captured result with no further M beats; after release, operation SHALL restart at word 0 of a new block with key register 0.

Configuration
REQ-022 With macro SM4_ADAPTER_TIMEOUT_EN defined: a 6-bit counter SHALL clear on RUN entry and increment each RUN cycle. If it reaches 63 without CORE_READY, ERR SHALL be set (sticky until RST), the block SHALL be discarded, and the FSM SHALL return to COLLECT with CORE_EN=0.
REQ-023 Without SM4_ADAPTER_TIMEOUT_EN: no counter, ERR SHALL be tied 0, and RUN SHALL wait indefinitely.

Verification
REQ-024 The bench SHALL use a behavioural SM4 core model (CORE_READY asserted 32 cycles after CORE_EN rises).
REQ-025 Known answer: KEY_IN=0123456789abcdeffedcba9876543210 with KEY_LOAD; S words 01234567, 89abcdef, fedcba98, 76543210 -> M words 681edf34, d206965e, 86b3e94f, 536e4246; ERR=0.
REQ-026 Backpressure: M_READY toggled 1-0-0-1 during EMIT -> M_DATA stable while stalled, exactly 4 beats, same values as REQ-025, S_READY=0 throughout EMIT.
REQ-027 Protocol timing: check CORE_RST_N=0 for exactly one cycle after the 4th S beat; CORE_EN=1 only in RUN; KEY_LOAD with KEY_IN=0 in RUN -> CORE_KEY unchanged and ciphertext still 681edf34...
REQ-028 Mid-operation reset: RST pulsed after 2 S beats, then a full block issued -> no M beats from the aborted block; the REQ-025 vectors, with the key reloaded, give the REQ-025 result.
REQ-029 Timeout (macro defined): core model never asserts CORE_READY -> ERR=1 after 63 RUN cycles, S_READY=1 the next cycle, ERR stays 1 until RST. Without the macro: ERR=0 and BUSY stays 1.
